uart_bus_bridge: RTL and testbench
==================================

// Module: uart_bus_bridge
// PURPOSE
//   CPU-side register front end for the UART core. Drives the core's control inputs
//   (i_en, i_br, i_clk_dec, i_str_tx, i_data_tx) and consumes its outputs (o_busy_tx,
//   o_RXNE, o_data_rx). Buffers TX and RX bytes in FIFOs and runs the str_tx/busy
//   handshake, so firmware never polls the core's short RXNE pulse.
// PARAMETERS
//   FIFO_DEPTH  8   entries per TX/RX FIFO; power of 2, >=2
//   CNT_W       4   log2(FIFO_DEPTH)+1; occupancy counter width
// PORTS
//   i_clk       in   1   system clock
//   i_rst       in   1   asynchronous active-low reset
//   i_addr      in   2   word select: 0 CTRL, 1 STATUS, 2 TXDATA, 3 RXDATA
//   i_we        in   1   write strobe, one cycle per access
//   i_re        in   1   read strobe, one cycle per access
//   i_wdata     in   32  write data
//   o_rdata     out  32  read data, registered
//   o_rvalid    out  1   o_rdata valid, one cycle after i_re
//   o_en        out  1   to UART i_en
//   o_br        out  4   to UART i_br
//   o_clk_dec   out  8   to UART i_clk_dec
//   o_str_tx    out  1   to UART i_str_tx
//   o_data_tx   out  8   to UART i_data_tx
//   i_busy_tx   in   1   from UART o_busy_tx
//   i_rxne      in   1   from UART o_RXNE; may stay high >1 cycle
//   i_data_rx   in   8   from UART o_data_rx
// BEHAVIOUR
//   Reset: all outputs 0; CTRL=0; both FIFOs empty; sticky flags 0; TX FSM in IDLE.
//   CTRL (RW): [0] EN, [7:4] BR, [15:8] CLK. Drives o_en/o_br/o_clk_dec directly.
//     [16] TXFLUSH, [17] RXFLUSH: write-1 empties that FIFO. Self-clearing; read as 0.
//   STATUS (RO except W1C): [0] TXBUSY = TX FIFO non-empty or FSM!=IDLE; [1] RXNE = RX non-empty;
//     [2] TXFULL; [3] RXFULL; [4] RXOVR sticky; [5] TXOVR sticky; W1C on [5:4];
//     [11:8] TX level; [15:12] RX level. Levels saturate at 15.
//   TXDATA write: pushes i_wdata[7:0]. If full: byte dropped, TXOVR<=1.
//     Write to a full FIFO in the same cycle as an FSM pop is accepted; level unchanged.
//   RXDATA read: o_rdata[7:0] = head byte; pops in the i_re cycle. Empty read returns 0, no pop.
//   Reads: o_rdata and o_rvalid are registered, latency 1. Write-only fields read as 0.
//   RX capture: push i_data_rx on the rising edge of i_rxne (registered i_rxne detect),
//     i.e. exactly one push per frame. If RX is full and not popping the same cycle:
//     byte dropped, RXOVR<=1.
//   TX FSM (IDLE, REQ, WAIT_DONE, GAP):
//     IDLE: TX non-empty and o_en -> pop into o_data_tx, o_str_tx<=1 -> REQ.
//     REQ: o_str_tx held, o_data_tx stable; i_busy_tx=1 -> WAIT_DONE.
//     WAIT_DONE: i_busy_tx=0 -> o_str_tx<=0 -> GAP.
//     GAP: one cycle with o_str_tx=0 so the core returns to idle -> IDLE.
//     o_data_tx is held stable from the pop until the FSM leaves GAP.
//   o_en=0 in any state: FSM -> IDLE next cycle, o_str_tx<=0, in-flight byte discarded.
//     FIFO contents and flags are kept; RX edge detect is inhibited.
//   Flush + push (or pop) in the same cycle: flush wins; FIFO ends empty.
// STRUCTURE
//   Package uart_bridge_pkg: register word offsets, CTRL/STATUS bit positions, TX FSM state enum.
//   Sub-module uart_fifo: sync FIFO with FIFO_DEPTH/CNT_W, push/pop/flush, full/empty/level,
//     async active-low reset. Instantiated twice (TX, RX). Bridge holds regs, edge detect, FSM.
// TESTING (bench pairs with the UART core, loopback TX->RX, CLK=27MHz value, BR=4'hF)
//   Write CTRL=0x1B_F1, TXDATA 0x55 -> o_str_tx rises 2 cycles later; 0x55 is read back
//     from RXDATA after one frame; RXOVR=0.
//   Write 8 bytes 0x00..0x07 back-to-back, then a 9th -> TXOVR=1, TX level=8;
//     all 8 bytes arrive in order.
//   Hold i_rxne high 2 cycles with i_data_rx=0xA3 (core stubbed) -> exactly one push; RX level=1.
//   Fill RX with 8 frames, send a 9th -> RXOVR=1 and 9th byte lost; W1C 0x10 -> RXOVR=0.
//   Clear EN mid-frame (FSM in WAIT_DONE) -> o_str_tx=0 next cycle; FSM IDLE; TX level unchanged.
//   Read RXDATA when empty -> o_rvalid=1, o_rdata=0, RX level stays 0; async reset mid-TX
//     -> all outputs 0 immediately.

Source files
------------

// File: rtl/uart_bridge_pkg.sv
// ============================================================================
// Module   : uart_bridge_pkg
// Purpose  : Register map, bit positions and TX FSM states for uart_bus_bridge
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_bridge_pkg;

   localparam logic [1:0] c_addr_ctrl   = 2'd0;
   localparam logic [1:0] c_addr_status = 2'd1;
   localparam logic [1:0] c_addr_txdata = 2'd2;
   localparam logic [1:0] c_addr_rxdata = 2'd3;

   localparam int c_ctrl_en       = 0;
   localparam int c_ctrl_br_lsb   = 4;
   localparam int c_ctrl_clk_lsb  = 8;
   localparam int c_ctrl_txflush  = 16;
   localparam int c_ctrl_rxflush  = 17;

   localparam int c_stat_txbusy    = 0;
   localparam int c_stat_rxne      = 1;
   localparam int c_stat_txfull    = 2;
   localparam int c_stat_rxfull    = 3;
   localparam int c_stat_rxovr     = 4;
   localparam int c_stat_txovr     = 5;
   localparam int c_stat_txlvl_lsb = 8;
   localparam int c_stat_rxlvl_lsb = 12;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_REQ       = 2'd1,
      ST_WAIT_DONE = 2'd2,
      ST_GAP       = 2'd3
   } tx_state_t;

   // Level fields are 4 bits wide regardless of FIFO depth.
   function automatic logic [3:0] f_sat_level(input logic [31:0] lvl);
      return (lvl > 32'd15) ? 4'hF : lvl[3:0];
   endfunction

endpackage

`default_nettype wire

// File: rtl/uart_fifo.sv
// ============================================================================
// Module   : uart_fifo
// Purpose  : Byte-wide synchronous FIFO with push/pop/flush and occupancy
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_fifo #(
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_W      = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic             i_flush,
   input  logic [7:0]       i_wdata,
   output logic [7:0]       o_rdata,
   output logic             o_full,
   output logic             o_empty,
   output logic [CNT_W-1:0] o_level
);

   localparam int c_ptr_w = $clog2(FIFO_DEPTH);

   logic [7:0]         r_mem [FIFO_DEPTH];
   logic [c_ptr_w-1:0] r_wr_ptr;
   logic [c_ptr_w-1:0] r_rd_ptr;
   logic [CNT_W-1:0]   r_count;
   logic               w_push_ok;
   logic               w_pop_ok;

   assign o_full    = (r_count == CNT_W'(FIFO_DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_level   = r_count;
   assign o_rdata   = r_mem[r_rd_ptr];
   // A push into a full FIFO is still taken when the head leaves in the same cycle.
   assign w_push_ok = i_push && (!o_full || i_pop);
   assign w_pop_ok  = i_pop && !o_empty;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
         r_count <= r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop_ok);
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push_ok && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
   end

endmodule

`default_nettype wire

// File: rtl/uart_bus_bridge.sv
// ============================================================================
// Module   : uart_bus_bridge
// Purpose  : CPU register front end for the UART core with TX/RX byte FIFOs
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_bus_bridge
   import uart_bridge_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_W      = 4
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [1:0]  i_addr,
   input  logic        i_we,
   input  logic        i_re,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_rdata,
   output logic        o_rvalid,
   output logic        o_en,
   output logic [3:0]  o_br,
   output logic [7:0]  o_clk_dec,
   output logic        o_str_tx,
   output logic [7:0]  o_data_tx,
   input  logic        i_busy_tx,
   input  logic        i_rxne,
   input  logic [7:0]  i_data_rx
);

   logic             r_en;
   logic [3:0]       r_br;
   logic [7:0]       r_clk_dec;
   logic             r_rxovr, r_txovr, r_rxne_q;
   logic [31:0]      r_rdata;
   logic             r_rvalid;
   tx_state_t        r_state, w_state_nxt;
   logic             r_str_tx, w_str_nxt;
   logic [7:0]       r_data_tx, w_data_nxt;
   logic             w_tx_pop;

   logic             w_wr_ctrl, w_wr_stat, w_wr_tx, w_rd_rx;
   logic             w_tx_flush, w_rx_flush, w_rx_push, w_rx_pop;
   logic             w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
   logic [7:0]       w_tx_head, w_rx_head;
   logic [CNT_W-1:0] w_tx_level, w_rx_level;
   logic [31:0]      w_status, w_rd_data;
   logic             w_unused;

   assign w_wr_ctrl  = i_we && (i_addr == c_addr_ctrl);
   assign w_wr_stat  = i_we && (i_addr == c_addr_status);
   assign w_wr_tx    = i_we && (i_addr == c_addr_txdata);
   assign w_rd_rx    = i_re && (i_addr == c_addr_rxdata);
   assign w_tx_flush = w_wr_ctrl && i_wdata[c_ctrl_txflush];
   assign w_rx_flush = w_wr_ctrl && i_wdata[c_ctrl_rxflush];
   // One push per frame even if the core holds RXNE for several cycles.
   assign w_rx_push  = i_rxne && !r_rxne_q && r_en;
   assign w_rx_pop   = w_rd_rx && !w_rx_empty;
   assign w_unused   = ^i_wdata[31:18];

   uart_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_tx_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (w_wr_tx),
      .i_pop   (w_tx_pop),
      .i_flush (w_tx_flush),
      .i_wdata (i_wdata[7:0]),
      .o_rdata (w_tx_head),
      .o_full  (w_tx_full),
      .o_empty (w_tx_empty),
      .o_level (w_tx_level)
   );

   uart_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_rx_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (w_rx_push),
      .i_pop   (w_rx_pop),
      .i_flush (w_rx_flush),
      .i_wdata (i_data_rx),
      .o_rdata (w_rx_head),
      .o_full  (w_rx_full),
      .o_empty (w_rx_empty),
      .o_level (w_rx_level)
   );

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_en      <= 1'b0;
         r_br      <= '0;
         r_clk_dec <= '0;
         r_rxovr   <= 1'b0;
         r_txovr   <= 1'b0;
         r_rxne_q  <= 1'b0;
      end else begin
         r_rxne_q <= i_rxne;
         if (w_wr_ctrl) begin
            r_en      <= i_wdata[c_ctrl_en];
            r_br      <= i_wdata[c_ctrl_br_lsb +: 4];
            r_clk_dec <= i_wdata[c_ctrl_clk_lsb +: 8];
         end
         if (w_wr_stat && i_wdata[c_stat_rxovr]) r_rxovr <= 1'b0;
         if (w_wr_stat && i_wdata[c_stat_txovr]) r_txovr <= 1'b0;
         if (w_rx_push && w_rx_full && !w_rx_pop) r_rxovr <= 1'b1;
         if (w_wr_tx && w_tx_full && !w_tx_pop)   r_txovr <= 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state   <= ST_IDLE;
         r_str_tx  <= 1'b0;
         r_data_tx <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_str_tx  <= w_str_nxt;
         r_data_tx <= w_data_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_str_nxt   = r_str_tx;
      w_data_nxt  = r_data_tx;
      w_tx_pop    = 1'b0;
      if (!r_en) begin
         w_state_nxt = ST_IDLE;
         w_str_nxt   = 1'b0;
         w_data_nxt  = '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (!w_tx_empty) begin
                  w_tx_pop    = 1'b1;
                  w_data_nxt  = w_tx_head;
                  w_str_nxt   = 1'b1;
                  w_state_nxt = ST_REQ;
               end
            end
            ST_REQ:       if (i_busy_tx) w_state_nxt = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
               if (!i_busy_tx) begin
                  w_str_nxt   = 1'b0;
                  w_state_nxt = ST_GAP;
               end
            end
            ST_GAP:       w_state_nxt = ST_IDLE;
            default:      w_state_nxt = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      w_status                            = '0;
      w_status[c_stat_txbusy]             = !w_tx_empty || (r_state != ST_IDLE);
      w_status[c_stat_rxne]               = !w_rx_empty;
      w_status[c_stat_txfull]             = w_tx_full;
      w_status[c_stat_rxfull]             = w_rx_full;
      w_status[c_stat_rxovr]              = r_rxovr;
      w_status[c_stat_txovr]              = r_txovr;
      w_status[c_stat_txlvl_lsb +: 4]     = f_sat_level(32'(w_tx_level));
      w_status[c_stat_rxlvl_lsb +: 4]     = f_sat_level(32'(w_rx_level));
   end

   always_comb begin
      w_rd_data = '0;
      case (i_addr)
         c_addr_ctrl: begin
            w_rd_data[c_ctrl_en]             = r_en;
            w_rd_data[c_ctrl_br_lsb +: 4]    = r_br;
            w_rd_data[c_ctrl_clk_lsb +: 8]   = r_clk_dec;
         end
         c_addr_status: w_rd_data = w_status;
         c_addr_rxdata: if (!w_rx_empty) w_rd_data[7:0] = w_rx_head;
         default:       w_rd_data = '0;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_rdata  <= '0;
         r_rvalid <= 1'b0;
      end else begin
         r_rvalid <= i_re;
         r_rdata  <= i_re ? w_rd_data : '0;
      end
   end

   assign o_rdata   = r_rdata;
   assign o_rvalid  = r_rvalid;
   assign o_en      = r_en;
   assign o_br      = r_br;
   assign o_clk_dec = r_clk_dec;
   assign o_str_tx  = r_str_tx;
   assign o_data_tx = r_data_tx;

endmodule

`default_nettype wire

// File: tb/tb_uart_bus_bridge.sv
// ============================================================================
// Module   : tb_uart_bus_bridge
// Purpose  : Directed bench for uart_bus_bridge with a behavioural UART loopback
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_bus_bridge;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b0;
   logic [1:0]  i_addr = '0;
   logic        i_we = 1'b0;
   logic        i_re = 1'b0;
   logic [31:0] i_wdata = '0;
   logic [31:0] o_rdata;
   logic        o_rvalid;
   logic        o_en;
   logic [3:0]  o_br;
   logic [7:0]  o_clk_dec;
   logic        o_str_tx;
   logic [7:0]  o_data_tx;
   logic        i_busy_tx;
   logic        i_rxne;
   logic [7:0]  i_data_rx;

   logic        stub_loop = 1'b0;
   logic        stub_busy = 1'b0;
   logic        stub_rxne = 1'b0;
   logic [7:0]  stub_data = '0;
   logic        man_rxne = 1'b0;
   logic [7:0]  man_data = '0;

   int checks = 0;
   int errors = 0;

   assign i_busy_tx = stub_loop ? stub_busy : 1'b0;
   assign i_rxne    = stub_loop ? stub_rxne : man_rxne;
   assign i_data_rx = stub_loop ? stub_data : man_data;

   uart_bus_bridge dut (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_addr    (i_addr),
      .i_we      (i_we),
      .i_re      (i_re),
      .i_wdata   (i_wdata),
      .o_rdata   (o_rdata),
      .o_rvalid  (o_rvalid),
      .o_en      (o_en),
      .o_br      (o_br),
      .o_clk_dec (o_clk_dec),
      .o_str_tx  (o_str_tx),
      .o_data_tx (o_data_tx),
      .i_busy_tx (i_busy_tx),
      .i_rxne    (i_rxne),
      .i_data_rx (i_data_rx)
   );

   initial forever #5 i_clk = ~i_clk;

   // Behavioural UART core: latches str_tx, is busy for a frame, then echoes the byte.
   initial begin : stub
      int phase;
      int cnt;
      logic [7:0] byte_q;
      phase = 0; cnt = 0; byte_q = '0;
      forever begin
         @(negedge i_clk);
         if (!stub_loop) begin
            phase = 0; cnt = 0;
            stub_busy = 1'b0; stub_rxne = 1'b0;
         end else begin
            case (phase)
               0: if (o_str_tx) begin byte_q = o_data_tx; cnt = 0; phase = 1; end
               1: begin
                  cnt++;
                  if (cnt == 2) begin stub_busy = 1'b1; cnt = 0; phase = 2; end
               end
               2: begin
                  cnt++;
                  if (cnt == 12) begin
                     stub_busy = 1'b0; stub_rxne = 1'b1; stub_data = byte_q; phase = 3;
                  end
               end
               default: begin
                  stub_rxne = 1'b0;
                  if (!o_str_tx) phase = 0;
               end
            endcase
         end
      end
   end

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      @(negedge i_clk);
      i_addr = a; i_wdata = d; i_we = 1'b1;
      @(negedge i_clk);
      i_we = 1'b0;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [31:0] d, output logic v);
      @(negedge i_clk);
      i_addr = a; i_re = 1'b1;
      @(negedge i_clk);
      i_re = 1'b0;
      d = o_rdata; v = o_rvalid;
   endtask

   task automatic poll_status(input logic [31:0] mask, input logic [31:0] want,
                              output logic ok, output logic [31:0] last);
      logic v;
      ok = 1'b0; last = '0;
      for (int n = 0; n < 400; n++) begin
         bus_read(2'd1, last, v);
         if ((last & mask) == want) begin ok = 1'b1; break; end
      end
   endtask

   task automatic test_reset();
      logic [31:0] d; logic v;
      i_rst = 1'b0;
      repeat (3) @(negedge i_clk);
      checks++;
      if ({o_en, o_br, o_clk_dec, o_str_tx, o_data_tx, o_rvalid, o_rdata} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got en=%b br=%h clk=%h str=%b dtx=%h rv=%b rd=%h expected all 0",
                  o_en, o_br, o_clk_dec, o_str_tx, o_data_tx, o_rvalid, o_rdata);
      end
      i_rst = 1'b1;
      bus_read(2'd1, d, v);
      checks++;
      if (v !== 1'b1 || d !== 32'h0) begin
         errors++; $display("FAIL reset_status: got v=%b d=%h expected v=1 d=00000000", v, d);
      end
      bus_read(2'd0, d, v);
      checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL reset_ctrl: got %h expected 00000000", d); end
      @(negedge i_clk);
      checks++;
      if (o_rvalid !== 1'b0) begin errors++; $display("FAIL rvalid_one_cycle: got %b expected 0", o_rvalid); end
   endtask

   task automatic test_basic_tx();
      logic [31:0] d; logic v, ok;
      stub_loop = 1'b1;
      bus_write(2'd0, 32'h0000_1BF1);
      checks++;
      if (o_en !== 1'b1 || o_br !== 4'hF || o_clk_dec !== 8'h1B) begin
         errors++; $display("FAIL ctrl_outputs: got en=%b br=%h clk=%h expected en=1 br=f clk=1b", o_en, o_br, o_clk_dec);
      end
      bus_read(2'd0, d, v);
      checks++;
      if (d !== 32'h0000_1BF1) begin errors++; $display("FAIL ctrl_readback: got %h expected 00001bf1", d); end
      @(negedge i_clk);
      i_addr = 2'd2; i_wdata = 32'h55; i_we = 1'b1;
      @(posedge i_clk); #1;
      checks++;
      if (o_str_tx !== 1'b0) begin errors++; $display("FAIL str_early: got %b expected 0", o_str_tx); end
      @(negedge i_clk);
      i_we = 1'b0;
      @(posedge i_clk); #1;
      checks++;
      if (o_str_tx !== 1'b1 || o_data_tx !== 8'h55) begin
         errors++; $display("FAIL str_rise: got str=%b data=%h expected str=1 data=55", o_str_tx, o_data_tx);
      end
      poll_status(32'h0000_F000, 32'h0000_1000, ok, d);
      checks++;
      if (!ok) begin errors++; $display("FAIL loopback_timeout: last status %h expected rx level 1", d); end
      bus_read(2'd3, d, v);
      checks++;
      if (v !== 1'b1 || d !== 32'h55) begin errors++; $display("FAIL rx_byte: got v=%b d=%h expected v=1 d=00000055", v, d); end
      bus_read(2'd1, d, v);
      checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL status_after_frame: got %h expected 00000000", d); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] d; logic v, ok;
      bus_write(2'd0, 32'h0000_1BF0);
      for (int i = 0; i < 9; i++) bus_write(2'd2, 32'(i));
      bus_read(2'd1, d, v);
      checks++;
      if (d !== 32'h0000_0825) begin errors++; $display("FAIL tx_overflow_status: got %h expected 00000825", d); end
      bus_write(2'd1, 32'h20);
      bus_read(2'd1, d, v);
      checks++;
      if (d !== 32'h0000_0805) begin errors++; $display("FAIL txovr_w1c: got %h expected 00000805", d); end
      bus_write(2'd0, 32'h0000_1BF1);
      poll_status(32'h0000_F000, 32'h0000_8000, ok, d);
      checks++;
      if (!ok) begin errors++; $display("FAIL burst_timeout: last status %h expected rx level 8", d); end
      bus_read(2'd1, d, v);
      checks++;
      if (d !== 32'h0000_800A) begin errors++; $display("FAIL rx_full_status: got %h expected 0000800a", d); end
      bus_write(2'd2, 32'h99);
      poll_status(32'h10, 32'h10, ok, d);
      checks++;
      if (!ok) begin errors++; $display("FAIL rxovr_timeout: last status %h expected rxovr set", d); end
      bus_read(2'd1, d, v);
      checks++;
      if (d !== 32'h0000_801A) begin errors++; $display("FAIL rx_overflow_status: got %h expected 0000801a", d); end
      for (int i = 0; i < 8; i++) begin
         bus_read(2'd3, d, v);
         checks++;
         if (d !== 32'(i)) begin errors++; $display("FAIL rx_order[%0d]: got %h expected %h", i, d, 32'(i)); end
      end
      bus_read(2'd3, d, v);
      checks++;
      if (v !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL rx_empty_read: got v=%b d=%h expected v=1 d=00000000", v, d); end
      bus_write(2'd1, 32'h10);
      bus_read(2'd1, d, v);
      checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL rxovr_w1c: got %h expected 00000000", d); end
   endtask

   task automatic test_rx_edge();
      logic [31:0] d; logic v;
      stub_loop = 1'b0;
      @(negedge i_clk);
      man_data = 8'hA3; man_rxne = 1'b1;
      repeat (2) @(negedge i_clk);
      man_rxne = 1'b0;
      bus_read(2'd1, d, v);
      checks++;
      if (d !== 32'h0000_1002) begin errors++; $display("FAIL rx_single_push: got %h expected 00001002", d); end
      bus_read(2'd3, d, v);
      checks++;
      if (d !== 32'hA3) begin errors++; $display("FAIL rx_edge_byte: got %h expected 000000a3", d); end
      bus_read(2'd1, d, v);
      checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL rx_edge_drain: got %h expected 00000000", d); end
   endtask

   task automatic test_en_abort();
      logic [31:0] d; logic v, got;
      stub_loop = 1'b1;
      bus_write(2'd2, 32'h11);
      bus_write(2'd2, 32'h22);
      bus_write(2'd2, 32'h33);
      got = 1'b0;
      for (int n = 0; n < 100; n++) begin
         @(negedge i_clk);
         if (i_busy_tx) begin got = 1'b1; break; end
      end
      checks++;
      if (!got) begin errors++; $display("FAIL abort_busy_timeout: got busy=%b expected 1", i_busy_tx); end
      @(negedge i_clk);
      i_addr = 2'd0; i_wdata = 32'h0000_1BF0; i_we = 1'b1;
      @(negedge i_clk);
      i_we = 1'b0;
      @(posedge i_clk); #1;
      checks++;
      if (o_str_tx !== 1'b0) begin errors++; $display("FAIL abort_str: got %b expected 0", o_str_tx); end
      repeat (5) @(negedge i_clk);
      checks++;
      if (o_str_tx !== 1'b0 || o_en !== 1'b0) begin
         errors++; $display("FAIL abort_idle: got str=%b en=%b expected str=0 en=0", o_str_tx, o_en);
      end
      bus_read(2'd1, d, v);
      checks++;
      if (d !== 32'h0000_0201) begin errors++; $display("FAIL abort_status: got %h expected 00000201", d); end
      bus_write(2'd0, 32'h0001_1BF0);
      repeat (25) @(negedge i_clk);
      bus_read(2'd1, d, v);
      checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL flush_status: got %h expected 00000000", d); end
      bus_read(2'd0, d, v);
      checks++;
      if (d !== 32'h0000_1BF0) begin errors++; $display("FAIL flush_selfclear: got %h expected 00001bf0", d); end
   endtask

   task automatic test_async_reset();
      logic [31:0] d; logic v, got;
      bus_write(2'd0, 32'h0000_1BF1);
      bus_write(2'd2, 32'h77);
      got = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(negedge i_clk);
         if (o_str_tx) begin got = 1'b1; break; end
      end
      checks++;
      if (!got) begin errors++; $display("FAIL reset_tx_timeout: got str=%b expected 1", o_str_tx); end
      @(posedge i_clk); #2;
      i_rst = 1'b0;
      #1;
      checks++;
      if ({o_en, o_br, o_clk_dec, o_str_tx, o_data_tx, o_rvalid, o_rdata} !== '0) begin
         errors++;
         $display("FAIL async_reset: got en=%b br=%h clk=%h str=%b dtx=%h expected all 0",
                  o_en, o_br, o_clk_dec, o_str_tx, o_data_tx);
      end
      stub_loop = 1'b0;
      @(negedge i_clk);
      i_rst = 1'b1;
      bus_read(2'd1, d, v);
      checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL post_reset_status: got %h expected 00000000", d); end
   endtask

   initial begin
      test_reset();
      test_basic_tx();
      test_back_to_back();
      test_rx_edge();
      test_en_abort();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
